// File: rtl/counter_updown_mod_pkg.sv
// ============================================================================
// counter_updown_mod_pkg : shared definitions for the counter family
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_updown_mod_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2, usable in parameter expressions by other counter variants
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_next_mod.sv
// ============================================================================
// counter_next_mod : combinational next-count and wrap detection, modulo MODULUS
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_next_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             wrap_flag_o
);

  // Compared at WIDTH+1 bits so MODULUS = 2^WIDTH does not overflow
  localparam logic [WIDTH:0] C_MOD = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] C_MAX = C_MOD - 1'b1;

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;

  assign q_ext   = {1'b0, q_i};
  assign inc_ext = q_ext + 1'b1;
  assign dec_ext = q_ext - 1'b1;

  always_comb begin
    next_q_o    = q_i;
    wrap_flag_o = 1'b0;
    if (up_i == DIR_UP) begin
      if (q_ext == C_MAX) begin
        next_q_o    = '0;
        wrap_flag_o = 1'b1;
      end else begin
        next_q_o = inc_ext[WIDTH-1:0];
      end
    end else begin
      if (q_ext == '0) begin
        next_q_o    = C_MAX[WIDTH-1:0];
        wrap_flag_o = 1'b1;
      end else begin
        next_q_o = dec_ext[WIDTH-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_updown_mod.sv
// ============================================================================
// counter_updown_mod : synchronous up/down modulo counter with load, Tc, Wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Wrap,
  output logic             LoadErr
);

  localparam logic [WIDTH:0] C_MOD = (WIDTH + 1)'(MODULUS);

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("counter_updown_mod: WIDTH %0d outside 2..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("counter_updown_mod: MODULUS %0d outside 2..2^WIDTH", MODULUS);
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             loaderr_q, loaderr_d;
  logic [WIDTH-1:0] next_q;
  logic             wrap_flag;

  counter_next_mod #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q_i         (q_q),
    .up_i        (Up),
    .next_q_o    (next_q),
    .wrap_flag_o (wrap_flag)
  );

  // Load wins over En; an out-of-range load leaves the count untouched
  always_comb begin
    q_d       = q_q;
    wrap_d    = 1'b0;
    loaderr_d = 1'b0;
    if (Load) begin
      if ({1'b0, D} < C_MOD) begin
        q_d = D;
      end else begin
        loaderr_d = 1'b1;
      end
    end else if (En) begin
      q_d    = next_q;
      wrap_d = wrap_flag;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q       <= '0;
      wrap_q    <= 1'b0;
      loaderr_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrap_q    <= wrap_d;
      loaderr_q <= loaderr_d;
    end
  end

  assign Q       = q_q;
  assign Wrap    = wrap_q;
  assign LoadErr = loaderr_q;
  // The wrap condition is exactly the terminal-count condition, independent of En
  assign Tc      = wrap_flag;

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// ============================================================================
// tb_counter_updown_mod : directed self-checking bench for counter_updown_mod
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_updown_mod;

  logic       Clk = 1'b0;
  logic       Reset, En, Up, Load;
  logic [3:0] D;
  logic [3:0] Q;
  logic       Tc, Wrap, LoadErr;

  logic       r16, en16, load16;
  logic [3:0] d16;
  logic [3:0] qa, qb;
  logic       tca, tcb, wrapa, wrapb, lea, leb;
  logic       enb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D(D),
    .Q(Q), .Tc(Tc), .Wrap(Wrap), .LoadErr(LoadErr)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(16)) u16a (
    .Clk(Clk), .Reset(r16), .En(en16), .Up(1'b1), .Load(load16), .D(d16),
    .Q(qa), .Tc(tca), .Wrap(wrapa), .LoadErr(lea)
  );

  assign enb = en16 & tca;

  counter_updown_mod #(.WIDTH(4), .MODULUS(16)) u16b (
    .Clk(Clk), .Reset(r16), .En(enb), .Up(1'b1), .Load(1'b0), .D(4'd0),
    .Q(qb), .Tc(tcb), .Wrap(wrapb), .LoadErr(leb)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1; En = 1; Up = 1; Load = 0; D = 0;
    tick(); tick();
    n_checks++; if (Q !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", Q); end
    n_checks++; if (Wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", Wrap); end
    n_checks++; if (LoadErr !== 1'b0) begin n_fail++; $display("FAIL reset_loaderr: got %b want 0", LoadErr); end
    n_checks++; if (Tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", Tc); end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q;
    Reset = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_q = 4'(k % 10);
      n_checks++; if (Q !== exp_q) begin n_fail++; $display("FAIL up_q[%0d]: got %0d want %0d", k, Q, exp_q); end
      n_checks++; if (Wrap !== (k == 10)) begin n_fail++; $display("FAIL up_wrap[%0d]: got %b want %b", k, Wrap, (k == 10)); end
      n_checks++; if (Tc !== (exp_q == 4'd9)) begin n_fail++; $display("FAIL up_tc[%0d]: got %b want %b", k, Tc, (exp_q == 4'd9)); end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'd9; exp_q[1] = 4'd8; exp_q[2] = 4'd7;
    Reset = 1; En = 1; Up = 0;
    tick();
    Reset = 0;
    #1;
    n_checks++; if (Tc !== 1'b1) begin n_fail++; $display("FAIL down_tc_at0: got %b want 1", Tc); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (Q !== exp_q[k]) begin n_fail++; $display("FAIL down_q[%0d]: got %0d want %0d", k, Q, exp_q[k]); end
      n_checks++; if (Wrap !== (k == 0)) begin n_fail++; $display("FAIL down_wrap[%0d]: got %b want %b", k, Wrap, (k == 0)); end
    end
  endtask

  task automatic test_load();
    Up = 1; En = 1; Load = 1; D = 4'd7;
    tick();
    n_checks++; if (Q !== 4'd7) begin n_fail++; $display("FAIL load_q: got %0d want 7", Q); end
    n_checks++; if (LoadErr !== 1'b0) begin n_fail++; $display("FAIL load_err_ok: got %b want 0", LoadErr); end
    D = 4'd12;
    tick();
    n_checks++; if (Q !== 4'd7) begin n_fail++; $display("FAIL badload_q: got %0d want 7", Q); end
    n_checks++; if (LoadErr !== 1'b1) begin n_fail++; $display("FAIL badload_err: got %b want 1", LoadErr); end
    Load = 0; En = 0;
    tick();
    n_checks++; if (LoadErr !== 1'b0) begin n_fail++; $display("FAIL badload_pulse: got %b want 0", LoadErr); end
    n_checks++; if (Q !== 4'd7) begin n_fail++; $display("FAIL badload_hold: got %0d want 7", Q); end
    // Boundary: D = MODULUS is rejected, D = MODULUS-1 accepted
    Load = 1; D = 4'd10;
    tick();
    n_checks++; if (LoadErr !== 1'b1 || Q !== 4'd7) begin n_fail++; $display("FAIL load_eq_mod: got err=%b q=%0d want err=1 q=7", LoadErr, Q); end
    D = 4'd9;
    tick();
    n_checks++; if (LoadErr !== 1'b0 || Q !== 4'd9) begin n_fail++; $display("FAIL load_max: got err=%b q=%0d want err=0 q=9", LoadErr, Q); end
    Load = 0;
  endtask

  task automatic test_hold_and_dir();
    Load = 1; D = 4'd4; En = 1;
    tick();
    Load = 0; En = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (Q !== 4'd4 || Wrap !== 1'b0) begin n_fail++; $display("FAIL hold[%0d]: got q=%0d wrap=%b want q=4 wrap=0", k, Q, Wrap); end
    end
    Load = 1; D = 4'd9; Up = 1;
    tick();
    Load = 0;
    #1;
    n_checks++; if (Tc !== 1'b1) begin n_fail++; $display("FAIL dir_tc_up: got %b want 1", Tc); end
    Up = 0;
    #1;
    n_checks++; if (Tc !== 1'b0) begin n_fail++; $display("FAIL dir_tc_down: got %b want 0", Tc); end
    En = 1;
    tick();
    n_checks++; if (Q !== 4'd8 || Wrap !== 1'b0) begin n_fail++; $display("FAIL dir_step: got q=%0d wrap=%b want q=8 wrap=0", Q, Wrap); end
    En = 0; Up = 1;
  endtask

  task automatic test_reset_priority();
    Load = 1; D = 4'd6;
    tick();
    Reset = 1; Load = 1; D = 4'd5; En = 1;
    tick();
    n_checks++; if (Q !== 4'd0 || LoadErr !== 1'b0) begin n_fail++; $display("FAIL reset_prio: got q=%0d err=%b want q=0 err=0", Q, LoadErr); end
    Reset = 0; Load = 0; En = 0;
  endtask

  task automatic test_mod16_cascade();
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    r16 = 1; en16 = 1; load16 = 0; d16 = 0;
    tick();
    r16 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_a = 4'(k % 16);
      exp_b = 4'(k / 16);
      n_checks++; if (qa !== exp_a || wrapa !== (k == 16)) begin n_fail++; $display("FAIL m16_a[%0d]: got q=%0d wrap=%b want q=%0d wrap=%b", k, qa, wrapa, exp_a, (k == 16)); end
      n_checks++; if (qb !== exp_b) begin n_fail++; $display("FAIL m16_b[%0d]: got %0d want %0d", k, qb, exp_b); end
    end
    en16 = 0; load16 = 1; d16 = 4'd15;
    tick();
    load16 = 0;
    n_checks++; if (qa !== 4'd15 || lea !== 1'b0) begin n_fail++; $display("FAIL m16_load15: got q=%0d err=%b want q=15 err=0", qa, lea); end
    n_checks++; if (qb !== 4'd1) begin n_fail++; $display("FAIL m16_b_load: got %0d want 1", qb); end
    en16 = 1;
    tick();
    n_checks++; if (qa !== 4'd0 || wrapa !== 1'b1) begin n_fail++; $display("FAIL m16_wrap2: got q=%0d wrap=%b want q=0 wrap=1", qa, wrapa); end
    n_checks++; if (qb !== 4'd2) begin n_fail++; $display("FAIL m16_b_step: got %0d want 2", qb); end
    en16 = 0;
  endtask

  initial begin
    Reset = 1; En = 0; Up = 1; Load = 0; D = 0;
    r16 = 1; en16 = 0; load16 = 0; d16 = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold_and_dir();
    test_reset_priority();
    test_mod16_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised synchronous up/down counter with a programmable modulus, parallel load, count enable, terminal-count and wrap outputs.
- Next-generation replacement for the fixed 4-bit ripple up counter; all flops sit on one clock, so there are no ripple glitches.
- Used as the general counting primitive in lab datapaths: dividers, sequencers and timers.

Parameters:
- WIDTH, 4, counter width in bits (range 2 to 16).
- MODULUS, 16, count range 0 to MODULUS-1. Legal range is 2 to 2^WIDTH; an elaboration-time check fails on any other value.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable.
- Up  input  1  direction: 1 = up, 0 = down.
- Load  input  1  parallel load strobe.
- D  input  WIDTH  parallel load value.
- Q  output  WIDTH  current count (registered).
- Tc  output  1  terminal count (combinational from Q and Up).
- Wrap  output  1  registered one-cycle pulse marking a wrap.
- LoadErr  output  1  registered one-cycle pulse marking a rejected load.

Behaviour:
- All state changes happen on the rising edge of Clk. Priority order: Reset > Load > En.
- Reset = 1 at an edge:
  - Q <= 0, Wrap <= 0, LoadErr <= 0.
  - Load and En are ignored in that cycle.
  - Reset asserted mid-count takes effect at the next edge, regardless of the other inputs.
- Load = 1 (Reset = 0):
  - If D < MODULUS: Q <= D, Wrap <= 0, LoadErr <= 0.
  - If D >= MODULUS: Q holds, LoadErr <= 1 for one cycle, Wrap <= 0.
  - Load overrides En; no count happens in a load cycle.
- En = 1, Load = 0:
  - Up = 1: Q <= Q+1. When Q = MODULUS-1, Q <= 0 and Wrap <= 1.
  - Up = 0: Q <= Q-1. When Q = 0, Q <= MODULUS-1 and Wrap <= 1.
  - Wrap <= 0 on every non-wrapping step.
- En = 0, Load = 0: Q holds, Wrap <= 0, LoadErr <= 0.
- Tc = 1 when (Up = 1 and Q = MODULUS-1) or (Up = 0 and Q = 0). It is independent of En, so it can be cascaded (next stage En = En & Tc).
- Changing Up between edges takes effect at the next edge; there is no extra latency.
- Width rules:
  - Next-value comparison is done at WIDTH+1 bits so MODULUS = 2^WIDTH is handled without overflow.
  - With MODULUS = 2^WIDTH, LoadErr can never assert.
- Latency: Q, Wrap and LoadErr update one edge after the inputs are sampled. Tc follows Q combinationally.
- No internal state beyond Q, Wrap and LoadErr; the block has no FSM states.

Decomposition:
- Shared package, used by all counter variants:
  - function clog2;
  - localparams for the direction encoding, DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
- Sub-module counter_next_mod: combinational. Takes Q, Up and MODULUS; returns next_q and a wrap_flag. Instantiated once. The top level holds the registers and the priority mux.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
- Reset = 1 for 2 edges with En = 1, Up = 1, then Reset = 0 and count 12 edges -> Q runs 0..9, 0, 1, 2. Wrap is high for exactly the cycle where Q = 0 after 9. Tc = 1 only while Q = 9.
- Up = 0 from reset, 3 edges -> Q = 9, 8, 7. Wrap pulses on the first edge (0 -> 9). Tc = 1 at Q = 0 before that edge.
- Load = 1, D = 7, with En = 1 -> Q = 7, no count. Then Load = 1, D = 12 -> Q stays 7, LoadErr = 1 for one cycle, then 0.
- En = 0 for 5 edges at Q = 4 -> Q stays 4, Wrap = 0. Toggle Up with Q = 9 -> Tc goes 1 -> 0 combinationally.
- Reset asserted together with Load = 1, D = 5, at Q = 6 -> Q = 0, LoadErr = 0.
- MODULUS = 16: 20 up edges -> Q wraps 15 -> 0 with a Wrap pulse. Load D = 15 is accepted with no LoadErr. Two counters cascaded (second stage En = Tc of the first) -> the second stage increments once per 16 counts.
